ring_phase_monitor: RTL and testbench

//  Downstream checker and decoder for the one-hot ring counter. Samples the ring output

---
 rtl/ring_phase_monitor_if.sv | 41 ++++
 rtl/ring_phase_monitor.sv | 163 ++++++++++++++++
 tb/tb_ring_phase_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_phase_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : ring_phase_monitor_if
//  Purpose  : Bundles the ring sample input, the counter clear and all status
//             outputs of ring_phase_monitor.
//  Ports    : none (signal bundle only)
//             master : drives ring_q/clr, observes the status outputs
//             slave  : the monitor side
//  Revision : 1.0 - initial release
// ============================================================================
interface ring_phase_monitor_if #(
  parameter int WIDTH = 3,
  parameter int REV_W = 8,
  parameter int ERR_W = 4
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] ring_q;
  logic             clr;
  logic [IDX_W-1:0] phase_idx;
  logic             phase_valid;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             resync_req;

  modport master (
    output ring_q, clr,
    input  phase_idx, phase_valid, locked, rev_tick, rev_count,
           err, err_count, resync_req
  );

  modport slave (
    input  ring_q, clr,
    output phase_idx, phase_valid, locked, rev_tick, rev_count,
           err, err_count, resync_req
  );
endinterface
`default_nettype wire

// File: rtl/ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : ring_phase_monitor
//  Purpose  : Samples a one-hot ring counter every rising clk edge, decodes the
//             active phase, locks onto the right-rotating sequence, counts
//             revolutions and rotation errors, and requests a resync after an
//             error until the ring is seen back at its reset code.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-low reset
//             mon  - ring_phase_monitor_if.slave
//                    in : ring_q, clr
//                    out: phase_idx, phase_valid, locked, rev_tick, rev_count,
//                         err, err_count, resync_req
//  Revision : 1.0 - initial release
// ============================================================================
module ring_phase_monitor #(
  parameter int WIDTH    = 3,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_phase_monitor_if.slave   mon
);
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t            state_q,       state_d;
  logic [WIDTH-1:0]  prev_q,        prev_d;
  logic [GOOD_W-1:0] good_cnt_q,    good_cnt_d;
  logic [IDX_W-1:0]  phase_idx_q,   phase_idx_d;
  logic              phase_valid_q, phase_valid_d;
  logic              locked_q,      locked_d;
  logic              rev_tick_q,    rev_tick_d;
  logic [REV_W-1:0]  rev_count_q,   rev_count_d;
  logic              err_q,         err_d;
  logic [ERR_W-1:0]  err_count_q,   err_count_d;
  logic              resync_req_q,  resync_req_d;

  logic              onehot;
  logic              legal;
  logic              at_reset_code;
  logic [IDX_W-1:0]  sample_idx;
  logic [WIDTH-1:0]  expected;

  always_comb begin
    // Single set bit: non-zero and clearing the lowest set bit leaves nothing.
    onehot     = (mon.ring_q != '0) && ((mon.ring_q & (mon.ring_q - WIDTH'(1))) == '0);
    sample_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mon.ring_q[i]) sample_idx = IDX_W'(i);
    end
    // Rotate-right successor of the previous sample; a zero or multi-hot
    // previous sample can never match a one-hot current sample.
    expected      = {prev_q[0], prev_q[WIDTH-1:1]};
    legal         = onehot && (mon.ring_q == expected);
    at_reset_code = onehot && mon.ring_q[WIDTH-1];
  end

  always_comb begin
    state_d       = state_q;
    prev_d        = mon.ring_q;
    good_cnt_d    = good_cnt_q;
    phase_idx_d   = onehot ? sample_idx : phase_idx_q;
    phase_valid_d = onehot;
    rev_tick_d    = 1'b0;
    rev_count_d   = rev_count_q;
    err_d         = 1'b0;
    err_count_d   = err_count_q;

    case (state_q)
      ST_SEEK: begin
        if (legal) begin
          if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end else begin
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (legal) begin
          if (mon.ring_q[WIDTH-1]) begin
            rev_tick_d  = 1'b1;
            rev_count_d = rev_count_q + REV_W'(1);
          end
        end else begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
        end
      end
      ST_ERROR: begin
        if (at_reset_code) begin
          state_d    = ST_SEEK;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_SEEK;
        good_cnt_d = '0;
      end
    endcase

    // Clear overrides any increment decided above.
    if (mon.clr) begin
      rev_count_d = '0;
      err_count_d = '0;
    end

    locked_d     = (state_d == ST_LOCKED);
    resync_req_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_SEEK;
      prev_q        <= '0;
      good_cnt_q    <= '0;
      phase_idx_q   <= '0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      rev_tick_q    <= 1'b0;
      rev_count_q   <= '0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      resync_req_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      good_cnt_q    <= good_cnt_d;
      phase_idx_q   <= phase_idx_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      rev_tick_q    <= rev_tick_d;
      rev_count_q   <= rev_count_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      resync_req_q  <= resync_req_d;
    end
  end

  assign mon.phase_idx   = phase_idx_q;
  assign mon.phase_valid = phase_valid_q;
  assign mon.locked      = locked_q;
  assign mon.rev_tick    = rev_tick_q;
  assign mon.rev_count   = rev_count_q;
  assign mon.err         = err_q;
  assign mon.err_count   = err_count_q;
  assign mon.resync_req  = resync_req_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_phase_monitor
//  Purpose  : Self-checking bench for ring_phase_monitor. Directed sequences
//             plus randomized ring codes, compared every cycle against a
//             phase-number based reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_phase_monitor;
  localparam int W  = 3;
  localparam int RW = 8;
  localparam int EW = 4;
  localparam int LC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_phase_monitor_if #(.WIDTH(W), .REV_W(RW), .ERR_W(EW)) bus ();

  ring_phase_monitor #(.WIDTH(W), .REV_W(RW), .ERR_W(EW), .LOCK_CNT(LC)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases are numbered by bit position; a legal step
  // moves the set bit one position lower, wrapping from bit 0 to bit W-1.
  int m_mode;   // 0 seeking, 1 locked, 2 error
  int m_prev, m_good, m_rev, m_err, m_idx, m_valid, m_tick, m_errp;

  function automatic int bit_pos(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) p = i;
    return p;
  endfunction

  function automatic bit is_onehot(input int v);
    int n = 0;
    for (int i = 0; i < W; i++) n += (v >> i) & 1;
    return (n == 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_rev = 0; m_err = 0;
    m_idx = 0; m_valid = 0; m_tick = 0; m_errp = 0;
  endtask

  task automatic model_step(input int v, input bit c);
    bit lg;
    lg = is_onehot(v) && is_onehot(m_prev) &&
         (bit_pos(v) == (bit_pos(m_prev) + W - 1) % W);
    m_valid = is_onehot(v);
    if (m_valid) m_idx = bit_pos(v);
    m_tick = 0;
    m_errp = 0;
    if (m_mode == 0) begin
      if (lg) begin
        m_good++;
        if (m_good >= LC) m_mode = 1;
      end else m_good = 0;
    end else if (m_mode == 1) begin
      if (lg) begin
        if (bit_pos(v) == W - 1) begin
          m_tick = 1;
          m_rev  = (m_rev + 1) % (1 << RW);
        end
      end else begin
        m_errp = 1;
        m_err  = (m_err < (1 << EW) - 1) ? m_err + 1 : m_err;
        m_mode = 2;
      end
    end else begin
      if (is_onehot(v) && bit_pos(v) == W - 1) begin
        m_mode = 0;
        m_good = 0;
      end
    end
    if (c) begin
      m_rev = 0;
      m_err = 0;
    end
    m_prev = v;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},      32'(bus.locked),      32'(m_mode == 1));
    chk({tag, ".resync_req"},  32'(bus.resync_req),  32'(m_mode == 2));
    chk({tag, ".rev_tick"},    32'(bus.rev_tick),    32'(m_tick));
    chk({tag, ".err"},         32'(bus.err),         32'(m_errp));
    chk({tag, ".rev_count"},   32'(bus.rev_count),   32'(m_rev));
    chk({tag, ".err_count"},   32'(bus.err_count),   32'(m_err));
    chk({tag, ".phase_valid"}, 32'(bus.phase_valid), 32'(m_valid));
    chk({tag, ".phase_idx"},   32'(bus.phase_idx),   32'(m_idx));
  endtask

  task automatic step(input string tag, input int v, input bit c);
    @(negedge clk);
    bus.ring_q = v[W-1:0];
    bus.clr    = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    check_all(tag);
  endtask

  task automatic rev(input string tag);
    step(tag, 4, 0);
    step(tag, 2, 0);
    step(tag, 1, 0);
  endtask

  int cur;

  initial begin
    bus.ring_q = '0;
    bus.clr    = 1'b0;
    rst        = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    // 1: lock after three samples, then ten revolutions
    step("t1_s1", 4, 0);
    step("t1_s2", 2, 0);
    step("t1_s3", 1, 0);
    chk("t1_locked_after_3", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 10; i++) rev("t1_rev");
    chk("t1_rev_count", 32'(bus.rev_count), 32'd10);

    // 2: multi-hot while locked, recover via reset code
    step("t2_multihot", 6, 0);
    chk("t2_err_pulse", 32'(bus.err), 32'd1);
    step("t2_exit", 4, 0);
    chk("t2_resync_low", 32'(bus.resync_req), 32'd0);
    step("t2_relock1", 2, 0);
    step("t2_relock2", 1, 0);
    chk("t2_relocked", 32'(bus.locked), 32'd1);

    // 3: wrong direction, then a held phase; zero while in error
    step("t3_a", 4, 0);
    step("t3_wrongdir", 1, 0);
    step("t3_zero", 0, 0);
    chk("t3_resync_held", 32'(bus.resync_req), 32'd1);
    rev("t3_relock");
    step("t3_b", 4, 0);
    step("t3_c", 2, 0);
    step("t3_hold", 2, 0);
    step("t3_hold2", 2, 0);
    chk("t3_err_count", 32'(bus.err_count), 32'd3);
    rev("t3_recover");
    rev("t3_relock2");

    // 4: revolution counter wrap and error counter saturation
    step("t4_clr", 4, 0);
    step("t4_clr", 2, 1);
    step("t4_clr", 1, 0);
    for (int i = 0; i < 256; i++) rev("t4_wrap");
    chk("t4_rev_wrapped", 32'(bus.rev_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step("t4_err", 6, 0);
      rev("t4_relock");
    end
    chk("t4_err_sat", 32'(bus.err_count), 32'd15);

    // 5: clear on the same edge as a revolution tick
    step("t5_clr_tick", 4, 1);
    chk("t5_rev0", 32'(bus.rev_count), 32'd0);
    chk("t5_err0", 32'(bus.err_count), 32'd0);
    chk("t5_locked", 32'(bus.locked), 32'd1);

    // randomized: mostly legal rotation with occasional arbitrary codes
    cur = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 85)
        cur = is_onehot(cur) ? ((cur >> 1) | ((cur & 1) << (W - 1))) : (1 << (W - 1));
      else
        cur = int'($urandom_range(0, (1 << W) - 1));
      step("rand", cur, ($urandom_range(0, 99) < 4));
    end
    rev("pre_t6");
    rev("pre_t6");

    // 6: asynchronous reset between edges while locked
    step("t6_pre", 4, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_locked0", 32'(bus.locked), 32'd0);
    chk("t6_resync0", 32'(bus.resync_req), 32'd0);
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    #2 rst = 1'b1;
    step("t6_first", 1, 0);
    step("t6_seek1", 4, 0);
    chk("t6_not_yet", 32'(bus.locked), 32'd0);
    step("t6_seek2", 2, 0);
    chk("t6_relocked", 32'(bus.locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
